// File: rtl/serial_sub_nbit.sv
// serial_sub_nbit: bit-serial N-bit subtractor with valid/ready handshakes; define SERIAL_SUB_OVF_EN for the signed-overflow output ovf.
module serial_sub_nbit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [N-1:0] sa, sb;
    logic [CW-1:0] cnt;
    logic br, d, br_n, last;
    always_comb begin
        d = sa[0] ^ sb[0] ^ br;
        br_n = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        last = cnt == CW'(N - 1);
        in_ready = (state == IDLE) && !rst;
        out_valid = state == DONE;
        state_n = (state == IDLE && in_valid) ? RUN :
                  (state == RUN && last) ? DONE :
                  (state == DONE && out_ready) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            br <= 1'b0;
            diff <= '0;
            bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                sa <= a;
                sb <= b;
                br <= 1'b0;
                cnt <= '0;
            end else if (state == RUN) begin
                sa <= sa >> 1;
                sb <= sb >> 1;
                br <= br_n;
                diff <= {d, diff[N-1:1]};
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    bout <= br_n;
`ifdef SERIAL_SUB_OVF_EN
                    ovf <= (sa[0] ^ sb[0]) & (sa[0] ^ d);
`endif
                end
            end
        end
    end
endmodule
